// File: rtl/ecall_service_unit_pkg.sv
// Shared service codes, state encoding and helpers for the ecall service unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ecall_service_unit_pkg;

  // Syscall numbers carried in a7.
  localparam logic [31:0] SYS_PRINT_INT = 32'd1;
  localparam logic [31:0] SYS_READ_INT  = 32'd5;
  localparam logic [31:0] SYS_EXIT      = 32'd10;
  localparam logic [31:0] SYS_READ_UINT = 32'd12;

  typedef enum logic [2:0] {
    ES_IDLE      = 3'd0,
    ES_PRINT     = 3'd1,
    ES_READ_WAIT = 3'd2,
    ES_READ_WB   = 3'd3,
    ES_DONE      = 3'd4,
    ES_HALT      = 3'd5
  } es_state_t;

  // True for either flavour of switch read.
  function automatic logic is_read_code(input logic [31:0] code);
    return (code == SYS_READ_INT) || (code == SYS_READ_UINT);
  endfunction

endpackage

// File: rtl/ecall_service_unit_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, counter debouncer, one-cycle rising-edge pulse.
// Latency: 2 sync cycles + DEBOUNCE_CYCLES stable cycles + 1 registered pulse cycle.
// Backpressure: none; the pulse is emitted once per accepted 0->1 level change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // Synchronise, then accept a new level only after it has held for DEBOUNCE_CYCLES.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      stable   <= 1'b0;
      cnt      <= '0;
      btn_rise <= 1'b0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      btn_rise <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable   <= sync2;
        cnt      <= '0;
        btn_rise <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ecall_service_unit.sv
// Services ecall (print/read/exit by a7), stalls the core meanwhile, writes reads to x10.
// Latency: print 1+PRINT_HOLD stall cycles; read waits for a fresh confirm press, then 1 write cycle.
// Backpressure: stall holds PC and suppresses core writes; ECALL_DEBOUNCE_EN adds a button debouncer.
module ecall_service_unit
  import ecall_service_unit_pkg::*;
#(
  parameter int SW_WIDTH        = 16,
  parameter int PRINT_HOLD      = 0,
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ecall,
  input  logic [31:0]         a7,
  input  logic [31:0]         a0,
  input  logic [SW_WIDTH-1:0] sw,
  input  logic                confirm_btn,
  output logic                stall,
  output logic                a0_we,
  output logic [31:0]         a0_wdata,
  output logic [31:0]         disp_data,
  output logic                disp_valid,
  output logic                wait_input,
  output logic                halted
);

  localparam int HOLD_W = (PRINT_HOLD > 1) ? $clog2(PRINT_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((PRINT_HOLD > 0) ? PRINT_HOLD - 1 : 0);

  if (SW_WIDTH < 1 || SW_WIDTH > 32 || DEBOUNCE_CYCLES < 1 || PRINT_HOLD < 0) begin : g_bad_param
    $error("ecall_service_unit: illegal parameter value");
  end

  es_state_t           state;
  es_state_t           state_nxt;
  logic                is_signed;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                print_fire;
  logic                btn_rise;
  logic signed [SW_WIDTH-1:0] sw_s;

  assign sw_s = sw;

`ifdef ECALL_DEBOUNCE_EN
  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (confirm_btn),
    .btn_rise (btn_rise)
  );
`else
  logic btn_sync1;
  logic btn_sync2;
  logic btn_prev;

  // Two-flop synchroniser plus a delayed copy for rising-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync1 <= 1'b0;
      btn_sync2 <= 1'b0;
      btn_prev  <= 1'b0;
    end else begin
      btn_sync1 <= confirm_btn;
      btn_sync2 <= btn_sync1;
      btn_prev  <= btn_sync2;
    end
  end

  assign btn_rise = btn_sync2 & ~btn_prev;
`endif

  // Next state and the combinational outputs; stall covers the ecall cycle itself.
  always_comb begin
    state_nxt  = state;
    stall      = 1'b0;
    a0_we      = 1'b0;
    wait_input = 1'b0;
    halted     = 1'b0;
    print_fire = 1'b0;
    case (state)
      ES_IDLE: begin
        if (ecall) begin
          stall = 1'b1;
          if (a7 == SYS_PRINT_INT) begin
            print_fire = 1'b1;
            state_nxt  = (PRINT_HOLD > 0) ? ES_PRINT : ES_DONE;
          end else if (is_read_code(a7)) begin
            state_nxt = ES_READ_WAIT;
          end else if (a7 == SYS_EXIT) begin
            state_nxt = ES_HALT;
          end else begin
            state_nxt = ES_DONE;
          end
        end
      end
      ES_PRINT: begin
        stall = 1'b1;
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = ES_DONE;
        end
      end
      ES_READ_WAIT: begin
        stall      = 1'b1;
        wait_input = 1'b1;
        if (btn_rise) begin
          state_nxt = ES_READ_WB;
        end
      end
      ES_READ_WB: begin
        stall     = 1'b1;
        a0_we     = 1'b1;
        state_nxt = ES_DONE;
      end
      ES_DONE: begin
        // Released for one cycle so the PC steps past this ecall before re-arming.
        state_nxt = ES_IDLE;
      end
      ES_HALT: begin
        stall  = 1'b1;
        halted = 1'b1;
      end
      default: begin
        state_nxt = ES_IDLE;
      end
    endcase
  end

  // Write data is zero outside the strobe so the regfile mux sees a quiet bus.
  always_comb begin
    a0_wdata = 32'd0;
    if (a0_we) begin
      a0_wdata = is_signed ? 32'(sw_s) : 32'(sw);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ES_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Captured service flavour, print hold counter and the display latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_signed  <= 1'b0;
      hold_cnt   <= '0;
      disp_data  <= 32'd0;
      disp_valid <= 1'b0;
    end else begin
      if (state == ES_IDLE && ecall) begin
        is_signed <= (a7 == SYS_READ_INT);
      end
      if (print_fire) begin
        disp_data  <= a0;
        disp_valid <= 1'b1;
      end
      hold_cnt <= (state == ES_PRINT) ? hold_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_ecall_service_unit.sv
// Bench for ecall_service_unit: per-cycle model comparison plus directed literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_ecall_service_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ecall;
  logic [31:0] a7;
  logic [31:0] a0;
  logic [15:0] sw;
  logic        confirm_btn;

  logic        stall, a0_we, disp_valid, wait_input, halted;
  logic [31:0] a0_wdata, disp_data;
  logic        stall_h, a0_we_h, disp_valid_h, wait_input_h, halted_h;
  logic [31:0] a0_wdata_h, disp_data_h;

  always #5 clk = ~clk;

  ecall_service_unit #(.SW_WIDTH(16), .PRINT_HOLD(0), .DEBOUNCE_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .ecall(ecall), .a7(a7), .a0(a0), .sw(sw),
    .confirm_btn(confirm_btn), .stall(stall), .a0_we(a0_we), .a0_wdata(a0_wdata),
    .disp_data(disp_data), .disp_valid(disp_valid), .wait_input(wait_input), .halted(halted)
  );

  ecall_service_unit #(.SW_WIDTH(16), .PRINT_HOLD(3), .DEBOUNCE_CYCLES(20)) dut_h (
    .clk(clk), .rst(rst), .ecall(ecall), .a7(a7), .a0(a0), .sw(sw),
    .confirm_btn(confirm_btn), .stall(stall_h), .a0_we(a0_we_h), .a0_wdata(a0_wdata_h),
    .disp_data(disp_data_h), .disp_valid(disp_valid_h), .wait_input(wait_input_h),
    .halted(halted_h)
  );

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  // ---------------- behavioural model (main instance, no print hold) ----------------
  localparam int M_HOLD = 0;
  bit          m_halt, m_wait, m_signed, m_wb, m_done;
  int          m_print;
  bit          h1, h2, h3;
  bit          m_edge;
  logic [31:0] md_data;
  bit          md_valid;
  bit          cmp_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_halt = 0; m_wait = 0; m_signed = 0; m_wb = 0; m_done = 0; m_print = 0;
      h1 = 0; h2 = 0; h3 = 0; md_data = 32'd0; md_valid = 0;
    end else begin
      // The button level reaches the service logic two samples late.
      m_edge = h2 & ~h3;
      if (m_halt) begin
      end else if (m_print > 0) begin
        if (m_print == 1) m_done = 1;
        m_print--;
      end else if (m_wait) begin
        if (m_edge) begin m_wait = 0; m_wb = 1; end
      end else if (m_wb) begin
        m_wb = 0; m_done = 1;
      end else if (m_done) begin
        m_done = 0;
      end else if (ecall) begin
        case (a7)
          32'd1: begin
            md_data = a0; md_valid = 1;
            if (M_HOLD > 0) m_print = M_HOLD; else m_done = 1;
          end
          32'd5:   begin m_wait = 1; m_signed = 1; end
          32'd12:  begin m_wait = 1; m_signed = 0; end
          32'd10:  m_halt = 1;
          default: m_done = 1;
        endcase
      end
      h3 = h2; h2 = h1; h1 = confirm_btn;
    end
  end

  // ---------------- per-cycle compare and event counters ----------------
  int          n_stall = 0, n_we = 0, n_stall_h = 0;
  logic [31:0] last_wd = 32'd0;

  always @(negedge clk) begin
    bit          idle;
    logic [31:0] exp_wd;
    if (cmp_en) begin
      idle   = !(m_halt || m_print > 0 || m_wait || m_wb || m_done);
      exp_wd = !m_wb ? 32'd0 : (m_signed ? {{16{sw[15]}}, sw} : {16'd0, sw});
      chkb("stall", stall, m_halt | (m_print > 0) | m_wait | m_wb | (idle & ecall));
      chkb("a0_we", a0_we, m_wb);
      chk("a0_wdata", a0_wdata, exp_wd);
      chk("disp_data", disp_data, md_data);
      chkb("disp_valid", disp_valid, md_valid);
      chkb("wait_input", wait_input, m_wait);
      chkb("halted", halted, m_halt);
      if (stall) n_stall++;
      if (stall_h) n_stall_h++;
      if (a0_we) begin n_we++; last_wd = a0_wdata; end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_we(input int base, input string nm);
    for (int i = 0; i < 20 && n_we == base; i++) tick();
    chkb(nm, n_we != base, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int bs, bw, bh;
    rst = 1; ecall = 0; a7 = 0; a0 = 0; sw = 0; confirm_btn = 0;
    tick();
    cmp_en = 1;
    tick();
    @(negedge clk);
    chkb("rst_stall", stall, 1'b0);
    chkb("rst_a0_we", a0_we, 1'b0);
    chk("rst_disp_data", disp_data, 32'd0);
    chkb("rst_disp_valid", disp_valid, 1'b0);
    chkb("rst_wait_input", wait_input, 1'b0);
    chkb("rst_halted", halted, 1'b0);
    tick();
    rst = 0;
    tick();

    // 1: print
    bs = n_stall; bw = n_we;
    a7 = 32'd1; a0 = 32'h0000_1234; ecall = 1;
    tick();
    ecall = 0;
    repeat (4) tick();
    chk("t1_stall_cycles", n_stall - bs, 32'd1);
    chk("t1_disp_data", disp_data, 32'h0000_1234);
    chkb("t1_disp_valid", disp_valid, 1'b1);
    chk("t1_no_write", n_we - bw, 32'd0);

    // 2: signed read
    sw = 16'hFFFE; a7 = 32'd5; ecall = 1; bw = n_we;
    tick();
    ecall = 0;
    repeat (3) tick();
    @(negedge clk);
    chkb("t2_wait_input", wait_input, 1'b1);
    tick();
    confirm_btn = 1;
    tick(); tick();
    confirm_btn = 0;
    wait_we(bw, "t2_write_seen");
    repeat (3) tick();
    chk("t2_wdata", last_wd, 32'hFFFF_FFFE);
    chk("t2_write_count", n_we - bw, 32'd1);

    // 3: unsigned read with the button already held
    a7 = 32'd12; confirm_btn = 1;
    repeat (4) tick();
    bw = n_we; ecall = 1;
    tick();
    ecall = 0;
    repeat (6) tick();
    chk("t3_no_early_write", n_we - bw, 32'd0);
    confirm_btn = 0;
    repeat (3) tick();
    confirm_btn = 1;
    wait_we(bw, "t3_write_seen");
    confirm_btn = 0;
    repeat (3) tick();
    chk("t3_wdata", last_wd, 32'h0000_FFFE);

    // 4: exit is sticky until reset
    a7 = 32'd10; ecall = 1; bw = n_we;
    tick();
    ecall = 0;
    tick();
    @(negedge clk);
    chkb("t4_halted", halted, 1'b1);
    chkb("t4_stall", stall, 1'b1);
    tick();
    a7 = 32'd1; a0 = 32'h0000_DEAD; ecall = 1; confirm_btn = 1;
    repeat (3) tick();
    ecall = 0; confirm_btn = 0;
    repeat (3) tick();
    @(negedge clk);
    chkb("t4_still_halted", halted, 1'b1);
    chk("t4_disp_kept", disp_data, 32'h0000_1234);
    chk("t4_no_write", n_we - bw, 32'd0);
    tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chkb("t4_rst_halted", halted, 1'b0);
    chkb("t4_rst_stall", stall, 1'b0);
    chk("t4_rst_disp_data", disp_data, 32'd0);
    chkb("t4_rst_disp_valid", disp_valid, 1'b0);
    tick();

    // 5: reset in the middle of a read
    a7 = 32'd5; ecall = 1; bw = n_we;
    tick();
    ecall = 0;
    repeat (3) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    chkb("t5_stall", stall, 1'b0);
    chkb("t5_wait_input", wait_input, 1'b0);
    tick();
    confirm_btn = 1;
    repeat (3) tick();
    confirm_btn = 0;
    repeat (5) tick();
    chk("t5_no_write", n_we - bw, 32'd0);

    // 6: unknown code then an immediately following print, ecall held as the core would
    bs = n_stall;
    a7 = 32'd99; ecall = 1;
    tick();
    tick();
    a7 = 32'd1; a0 = 32'h0000_55AA;
    tick();
    tick();
    ecall = 0;
    repeat (3) tick();
    chk("t6_stall_cycles", n_stall - bs, 32'd2);
    chk("t6_disp_data", disp_data, 32'h0000_55AA);

    // 6b: print with a three-cycle hold on the second instance
    rst = 1;
    tick();
    rst = 0;
    tick();
    bh = n_stall_h; bs = n_stall;
    a7 = 32'd1; a0 = 32'h0000_0077; ecall = 1;
    tick();
    ecall = 0;
    repeat (8) tick();
    chk("t6h_stall_cycles", n_stall_h - bh, 32'd4);
    chk("t6h_disp_data", disp_data_h, 32'h0000_0077);
    chk("t6_main_stall_cycles", n_stall - bs, 32'd1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
